// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter for two masters over one single-port data RAM with bounded burst locking.
// Optional saturating grant/conflict counters when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          lock0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          lock1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_gnt0,
  output logic [15:0]   stat_gnt1,
  output logic [15:0]   stat_conflict
`endif
);
  localparam logic [3:0] MB = 4'(MAX_BURST);
  logic last_gnt, lock_vld, lock_id, rd_vld, rd_id;
  logic [3:0] burst_cnt, nxt_cnt;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic lock_hit, sel, act, lk, keep_lock;
  always_comb begin
    lock_hit = lock_vld && (lock_id ? req1 : req0) && burst_cnt < MB;
    sel = lock_hit ? lock_id : (req0 && req1) ? ~last_gnt : req1;
    act = reset && (req0 || req1);
    gnt0 = act && !sel;
    gnt1 = act && sel;
    mem_en = act;
    mem_we = act && (sel ? we1 : we0);
    mem_addr = act ? (sel ? addr1 : addr0) : '0;
    mem_wdata = act ? (sel ? wdata1 : wdata0) : '0;
    lk = sel ? lock1 : lock0;
    // a new lock owner starts counting from zero
    nxt_cnt = ((lock_vld && lock_id == sel) ? burst_cnt : 4'd0) + 4'd1;
    keep_lock = act && lk && nxt_cnt != MB;
    rvalid0 = rd_vld && !rd_id;
    rvalid1 = rd_vld && rd_id;
    rdata0 = rvalid0 ? mem_rdata : rdata0_q;
    rdata1 = rvalid1 ? mem_rdata : rdata1_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gnt <= 1'b1;
      lock_vld <= 1'b0;
      lock_id <= 1'b0;
      burst_cnt <= '0;
      rd_vld <= 1'b0;
      rd_id <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;
      rd_vld <= act && !mem_we;
      rd_id <= sel;
      if (act) last_gnt <= sel;
      lock_vld <= keep_lock;
      lock_id <= sel;
      burst_cnt <= keep_lock ? nxt_cnt : 4'd0;
    end
  end
`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_gnt0 <= '0;
      stat_gnt1 <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
      if (req0 && req1 && stat_conflict != 16'hFFFF) stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus randomized run against a rule-level arbiter model.
module tb_dmem_arbiter;
  localparam int AW = 32, DW = 32, MB = 4;
  logic clk = 0, reset = 0;
  logic req0 = 0, lock0 = 0, we0 = 0, req1 = 0, lock1 = 0, we1 = 0;
  logic [31:0] addr0 = 0, wdata0 = 0, addr1 = 0, wdata1 = 0, mem_rdata = 0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .lock0(lock0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .lock1(lock1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic g0, input logic g1, input logic mwe,
                         input logic [31:0] ma, input logic [31:0] md, input logic v0, input logic v1,
                         input logic [31:0] rd0, input logic [31:0] rd1);
    chk({tag, " gnt0"}, 32'(gnt0), 32'(g0));
    chk({tag, " gnt1"}, 32'(gnt1), 32'(g1));
    chk({tag, " mem_en"}, 32'(mem_en), 32'(g0 | g1));
    chk({tag, " mem_we"}, 32'(mem_we), 32'(mwe));
    chk({tag, " mem_addr"}, mem_addr, ma);
    chk({tag, " mem_wdata"}, mem_wdata, md);
    chk({tag, " rvalid0"}, 32'(rvalid0), 32'(v0));
    chk({tag, " rvalid1"}, 32'(rvalid1), 32'(v1));
    chk({tag, " rdata0"}, rdata0, rd0);
    chk({tag, " rdata1"}, rdata1, rd1);
  endtask

  typedef struct {
    logic rst, r0, l0, w0;
    logic [31:0] a0, d0;
    logic r1, l1, w1;
    logic [31:0] a1, d1, mrd;
    logic g0, g1, mwe;
    logic [31:0] ma, md;
    logic v0, v1;
    logic [31:0] rd0, rd1;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic rst, r0, l0, w0, input logic [31:0] a0, d0,
                     input logic r1, l1, w1, input logic [31:0] a1, d1, mrd,
                     input logic g0, g1, mwe, input logic [31:0] ma, md,
                     input logic v0, v1, input logic [31:0] rd0, rd1);
    vec_t v;
    v = '{rst, r0, l0, w0, a0, d0, r1, l1, w1, a1, d1, mrd, g0, g1, mwe, ma, md, v0, v1, rd0, rd1};
    tbl.push_back(v);
  endtask

  // rule-level model: owner -1 means no lock, pend -1 means no read in flight
  int m_last, m_owner, m_cnt, m_pend, g;
  logic [31:0] m_rd[2];
  logic rq[2], lq[2], wq[2];
  logic [31:0] aq[2], dq[2];

  task automatic mreset();
    m_last = 1; m_owner = -1; m_cnt = 0; m_pend = -1; m_rd[0] = 0; m_rd[1] = 0;
  endtask

  function automatic int mgnt();
    if (!reset) return -1;
    if (m_owner >= 0 && rq[m_owner] && m_cnt < MB) return m_owner;
    if (rq[0] && rq[1]) return 1 - m_last;
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  task automatic mupdate(input int gg);
    if (m_pend >= 0) m_rd[m_pend] = mem_rdata;
    m_pend = (gg >= 0 && !wq[gg]) ? gg : -1;
    if (gg >= 0 && lq[gg]) begin
      m_cnt = (m_owner == gg ? m_cnt : 0) + 1;
      m_owner = gg;
      if (m_cnt == MB) begin m_owner = -1; m_cnt = 0; end
    end else begin
      m_owner = -1; m_cnt = 0;
    end
    if (gg >= 0) m_last = gg;
  endtask

  localparam logic [31:0] DB = 32'hDEADBEEF, W = 32'h12345678;
  localparam logic [31:0] A0 = 32'hA0000000, A1 = 32'hA0000001, A2 = 32'hA0000002, A3 = 32'hA0000003, A4 = 32'hA0000004;
  localparam logic [31:0] B0 = 32'hB0000000, B1 = 32'hB0000001, B2 = 32'hB0000002, B3 = 32'hB0000003;
  localparam logic [31:0] B4 = 32'hB0000004, B5 = 32'hB0000005, B6 = 32'hB0000006, B7 = 32'hB0000007;
  localparam logic [31:0] C0 = 32'hC0000000, C1 = 32'hC0000001;

  initial begin
    // read right after reset, then a port 1 write
    add(1, 1,0,0,'h10,0, 0,0,0,0,0, DB,  1,0,0,'h10,0, 0,0,0,0);
    add(1, 0,0,0,0,0,    0,0,0,0,0, DB,  0,0,0,0,0,    1,0,DB,0);
    add(1, 0,0,0,0,0,    1,0,1,'h20,W, 0, 0,1,1,'h20,W, 0,0,DB,0);
    add(1, 0,0,0,0,0,    0,0,0,0,0, 'h55, 0,0,0,0,0,   0,0,DB,0);
    // contention without lock alternates 0,1,0,1
    add(1, 1,0,0,'h30,0, 1,0,0,'h40,0, A0, 1,0,0,'h30,0, 0,0,DB,0);
    add(1, 1,0,0,'h30,0, 1,0,0,'h40,0, A1, 0,1,0,'h40,0, 1,0,A1,0);
    add(1, 1,0,0,'h30,0, 1,0,0,'h40,0, A2, 1,0,0,'h30,0, 0,1,A1,A2);
    add(1, 1,0,0,'h30,0, 1,0,0,'h40,0, A3, 0,1,0,'h40,0, 1,0,A3,A2);
    add(1, 0,0,0,0,0,    0,0,0,0,0,    A4, 0,0,0,0,0,    0,1,A3,A4);
    // port 1 locks: 4 consecutive grants then port 0
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B0, 1,0,0,'h30,0, 0,0,A3,A4);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B1, 0,1,0,'h40,0, 1,0,B1,A4);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B2, 0,1,0,'h40,0, 0,1,B1,B2);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B3, 0,1,0,'h40,0, 0,1,B1,B3);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B4, 0,1,0,'h40,0, 0,1,B1,B4);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B5, 1,0,0,'h30,0, 0,1,B1,B5);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, B6, 0,1,0,'h40,0, 1,0,B6,B5);
    // reset mid-burst with a read in flight
    add(0, 1,0,0,'h30,0, 1,1,0,'h40,0, B7, 0,0,0,0,0,    0,0,0,0);
    add(1, 1,0,0,'h30,0, 1,1,0,'h40,0, C0, 1,0,0,'h30,0, 0,0,0,0);
    add(1, 0,0,0,0,0,    0,0,0,0,0,    C1, 0,0,0,0,0,    1,0,C1,0);

    repeat (2) @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      req0 = tbl[i].r0; lock0 = tbl[i].l0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; lock1 = tbl[i].l1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      mem_rdata = tbl[i].mrd;
      #1;
      chk_all($sformatf("row%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].mwe, tbl[i].ma, tbl[i].md,
              tbl[i].v0, tbl[i].v1, tbl[i].rd0, tbl[i].rd1);
    end

    g = -1;
    for (int p = 0; p < 2; p++) begin rq[p] = 0; lq[p] = 0; wq[p] = 0; aq[p] = 0; dq[p] = 0; end
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = (c == 0) ? 1'b0 : ($urandom_range(0, 79) != 0);
      for (int p = 0; p < 2; p++)
        if (!rq[p] || g == p) begin
          rq[p] = $urandom_range(0, 3) != 0;
          lq[p] = $urandom_range(0, 3) != 0;
          wq[p] = $urandom_range(0, 2) == 0;
          aq[p] = $urandom;
          dq[p] = $urandom;
        end
      req0 = rq[0]; lock0 = lq[0]; we0 = wq[0]; addr0 = aq[0]; wdata0 = dq[0];
      req1 = rq[1]; lock1 = lq[1]; we1 = wq[1]; addr1 = aq[1]; wdata1 = dq[1];
      mem_rdata = $urandom;
      #1;
      if (!reset) mreset();
      g = mgnt();
      chk_all($sformatf("rnd%0d", c), g == 0, g == 1, g >= 0 && wq[g], g >= 0 ? aq[g] : 32'h0,
              g >= 0 ? dq[g] : 32'h0, m_pend == 0, m_pend == 1,
              m_pend == 0 ? mem_rdata : m_rd[0], m_pend == 1 ? mem_rdata : m_rd[1]);
      @(posedge clk);
      if (reset) mupdate(g);
    end

`ifdef DMEM_ARB_STATS_EN
    @(negedge clk);
    reset = 0; req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 1; we1 = 1;
    @(negedge clk);
    reset = 1; req0 = 1; req1 = 1;
    repeat (10) @(negedge clk);
    #1;
    chk("stat_conflict10", 32'(stat_conflict), 32'd10);
    chk("stat_gnt_sum10", 32'(stat_gnt0) + 32'(stat_gnt1), 32'd10);
    repeat (65540) @(negedge clk);
    #1;
    chk("stat_conflict_sat", 32'(stat_conflict), 32'hFFFF);
    chk("stat_gnt_sum_big", 32'(stat_gnt0) + 32'(stat_gnt1), 32'd65550);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one single-port data memory between two requesters: port 0 is the processor data port (load/store path, write-enable and write-data); port 1 is a secondary master (loader/DMA/debug).
- Sits between computer_top's datapath and the data RAM.
- Round-robin arbitration with optional bounded locking for bursts.
- Memory read latency is 1 cycle.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- MAX_BURST, 4, maximum consecutive grants to a locking master (range 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request, processor side.
- lock0  input  1  port 0 wants to keep the grant next cycle.
- we0  input  1  port 0 write enable.
- addr0  input  AW  port 0 address.
- wdata0  input  DW  port 0 write data.
- gnt0  output  1  port 0 access accepted this cycle.
- rvalid0  output  1  port 0 read data valid.
- rdata0  output  DW  port 0 read data.
- req1, lock1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write strobe.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset (reset=0, asynchronous): last_gnt=1, so port 0 wins first. lock_owner=none, burst_cnt=0, rvalid0/1=0, rdata0/1=0, rd_owner=none.
- Combinational outputs while reset=0: gnt0/1, mem_en and mem_we are forced to 0.
- Handshake: a transfer occurs in a cycle where reqN=1 and gntN=1. The master holds req/we/addr/wdata stable until granted. Grants are combinational in the same cycle; no wait states when uncontested.
- At most one gnt per cycle.
- mem_en = gnt0|gnt1. mem_we, mem_addr and mem_wdata are muxed from the granted port. With no grant, mem_addr and mem_wdata are 0 and mem_we=0.
- Arbitration order:
  1. If lock_owner=N and reqN=1 and burst_cnt<MAX_BURST: grant N.
  2. Otherwise, if only one port requests: grant it.
  3. Otherwise, if both request: grant the port != last_gnt.
- On each grant:
  - last_gnt <= granted port.
  - If lockN=1, lock_owner <= N and burst_cnt <= burst_cnt+1.
  - If lockN=0, lock_owner <= none and burst_cnt <= 0.
- Lock release:
  - Lock ends when the owner drops req, drops lock, or burst_cnt reaches MAX_BURST. On MAX_BURST, clear lock_owner and burst_cnt, and the other port wins next if it requests.
  - A lock owner that deasserts req releases the lock immediately; no idle cycles are reserved for it.
- Read return:
  - A granted read (we=0) sets rd_owner<=N. Next cycle: rvalidN=1 and rdataN=mem_rdata (registered capture, 1-cycle pulse).
  - rdataN holds its value until the next read completes for that port.
  - Writes produce no rvalid.
- Back-to-back reads from alternating ports each return in order, one per cycle; rvalid0 and rvalid1 are never both 1.
- Reset mid-burst: the lock is dropped, and any in-flight rvalid is suppressed because its register is cleared.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds output ports stat_gnt0, stat_gnt1 (16 bits, saturating grant counters) and stat_conflict (16 bits, saturating count of cycles with req0&req1).
  - All counters clear on reset.
  - Counters saturate at 16'hFFFF; they never wrap.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset release, req0=1 we0=0 addr0=0x10, mem_rdata=0xDEADBEEF -> gnt0=1 the same cycle, mem_addr=0x10, then rvalid0=1 with rdata0=0xDEADBEEF one cycle later, rvalid1=0.
2. req0=req1=1 held for 4 cycles, no lock -> grants alternate 0,1,0,1; rvalids alternate accordingly.
3. req1=lock1=1 with req0=1 continuously, MAX_BURST=4 -> port 1 granted 4 consecutive cycles, then gnt0=1 on cycle 5.
4. Write: req1=1 we1=1 addr1=0x20 wdata1=0x12345678 -> mem_we=1, mem_wdata=0x12345678, no rvalid1.
5. reset asserted during a locked burst after a read grant -> gnt/mem_en drop immediately, rvalid is 0 the next cycle, and after release port 0 wins the first contention.
6. With DMEM_ARB_STATS_EN and 10 contended cycles -> stat_conflict=10 and stat_gnt0+stat_gnt1=10; the counters stop at 0xFFFF when driven past saturation.
